// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control constants and types.
package rf_ctrl_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at/after the pointer.
// The pointer moves to just past the granted requester on every grant.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [PW-1:0] ptr
);
  logic [2*N-1:0] req_rot;
  logic [PW-1:0]  gnt_idx;
  logic           any_gnt;

  // Rotating the doubled request vector puts requester ptr at bit 0.
  assign req_rot = {req, req} >> ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req_rot[k]) begin
        any_gnt = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % N);
      end
    end
    if (any_gnt) gnt = N'(1) << gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port sequencer with round-robin writeback arbitration
// and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_WB = 3,
  localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     issue_valid,
  input  reg_addr_t                issue_rs1,
  input  reg_addr_t                issue_rs2,
  input  reg_addr_t                issue_rd,
  input  logic                     issue_wr,
  output logic                     issue_ready,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ADDR_W-1:0] wb_rd,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  output logic [NUM_WB-1:0]        wb_ready,
  output logic                     rf_we,
  output reg_addr_t                rf_reg_c,
  output word_t                    rf_data_c,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     err_spur,
  output logic [PTR_W-1:0]         rr_ptr
);
  // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
  // Issue may withdraw valid without ready; writeback requesters hold
  // valid/rd/data stable until they see ready.
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rf_we_q;
  reg_addr_t           sel_rd;
  word_t               sel_data;
  logic                wb_any;
  logic                write_go;

  rr_arbiter #(.N(NUM_WB)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (wb_valid),
    .gnt   (wb_ready),
    .ptr   (rr_ptr)
  );

  assign issue_ready = en & issue_valid & ~busy_q[issue_rs1] & ~busy_q[issue_rs2]
                     & ~(issue_wr & busy_q[issue_rd]);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_ready[i]) begin
        sel_rd   = sel_rd | wb_rd[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wb_any   = |wb_ready;
  assign write_go = wb_any && (sel_rd != '0);

  // Clear on register-file commit, then set on issue; set wins on a collision.
  always_comb begin
    busy_nxt = busy_q;
    if (rf_we_q) busy_nxt[rf_reg_c] = 1'b0;
    if (issue_ready && issue_wr && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_reg_c  <= '0;
      rf_data_c <= '0;
      err_spur  <= 1'b0;
    end else if (en) begin
      busy_q  <= busy_nxt;
      rf_we_q <= write_go;
      if (write_go) begin
        rf_reg_c  <= sel_rd;
        rf_data_c <= sel_data;
      end
      if (write_go && !busy_q[sel_rd]) err_spur <= 1'b1;
    end
  end

  assign rf_we = rf_we_q & en;
  assign busy  = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized bench for regfile_wb_scheduler, checked against a
// behavioural model of the scoreboard, round-robin order and write port.
module tb_regfile_wb_scheduler;
  import rf_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int QW = ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 en, issue_valid, issue_wr, issue_ready;
  reg_addr_t            issue_rs1, issue_rs2, issue_rd;
  logic [N-1:0]         wb_valid, wb_ready;
  logic [N*ADDR_W-1:0]  wb_rd;
  logic [N*DATA_W-1:0]  wb_data;
  logic                 rf_we, err_spur;
  reg_addr_t            rf_reg_c;
  word_t                rf_data_c;
  logic [NUM_REGS-1:0]  busy;
  logic [1:0]           rr_ptr;

  regfile_wb_scheduler #(.NUM_WB(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_we(rf_we), .rf_reg_c(rf_reg_c), .rf_data_c(rf_data_c),
    .busy(busy), .err_spur(err_spur), .rr_ptr(rr_ptr)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [NUM_REGS-1:0] m_busy;
  int                  m_ptr;
  logic                m_we;
  reg_addr_t           m_reg;
  word_t               m_data;
  logic                m_err;
  logic [QW-1:0]       exp_q[$];
  logic                obs_rdy;
  logic [N-1:0]        obs_gnt;
  int                  last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_err = 1'b0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    wb_valid = '0;
  endtask

  task automatic set_issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                           input logic wr);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_wr = wr;
  endtask

  task automatic set_wb(input int i, input logic v, input reg_addr_t rd, input word_t d);
    wb_valid[i] = v;
    wb_rd[i*ADDR_W +: ADDR_W] = rd;
    wb_data[i*DATA_W +: DATA_W] = d;
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic cycle();
    logic          exp_rdy;
    logic [N-1:0]  exp_gnt;
    logic [NUM_REGS-1:0] old_busy;
    int            g, idx;
    reg_addr_t     grd;
    word_t         gdat;
    logic [QW-1:0] e;
    #1;
    exp_rdy = en && issue_valid && !m_busy[issue_rs1] && !m_busy[issue_rs2]
              && !(issue_wr && m_busy[issue_rd]);
    g = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && wb_valid[idx[1:0]]) g = idx;
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g[1:0]] = 1'b1;

    chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
    chk("wb_ready", 64'(wb_ready), 64'(exp_gnt));
    chk("rf_we", 64'(rf_we), 64'(en && m_we));
    chk("rf_reg_c", 64'(rf_reg_c), 64'(m_reg));
    chk("rf_data_c", 64'(rf_data_c), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("err_spur", 64'(err_spur), 64'(m_err));
    chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    if (en && m_we) begin
      chk("wr_queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_commit", 64'({rf_reg_c, rf_data_c}), 64'(e));
      end
    end
    obs_rdy = issue_ready;
    obs_gnt = wb_ready;
    last_g  = g;

    if (!rst_n) begin
      model_reset();
    end else if (en) begin
      old_busy = m_busy;
      if (m_we) m_busy[m_reg] = 1'b0;
      if (exp_rdy && issue_wr && issue_rd != '0) m_busy[issue_rd] = 1'b1;
      if (g >= 0) begin
        grd  = wb_rd[g*ADDR_W +: ADDR_W];
        gdat = wb_data[g*DATA_W +: DATA_W];
        if (grd != '0 && !old_busy[grd]) m_err = 1'b1;
        m_we = (grd != '0);
        if (grd != '0) begin
          m_reg = grd; m_data = gdat;
          exp_q.push_back({grd, gdat});
        end
        m_ptr = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]        rv;
  reg_addr_t           rrd [N];
  word_t               rdat[N];
  logic [NUM_REGS-1:0] pend;
  reg_addr_t           r;

  initial begin
    rst_n = 1'b0; en = 1'b1; wb_rd = '0; wb_data = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_reg_c", 64'(rf_reg_c), 64'(0));
    chk("rst_err", 64'(err_spur), 64'(0));
    chk("rst_ptr", 64'(rr_ptr), 64'(0));

    // Independent issue, then rd=3 becomes busy.
    set_issue(5'd1, 5'd2, 5'd3, 1'b1);
    cycle();
    chk("s1_ready", 64'(obs_rdy), 64'(1));
    idle();
    chk("s1_busy3", 64'(busy[3]), 64'(1));

    // RAW stall on x3 until the register file commits.
    set_issue(5'd3, 5'd0, 5'd0, 1'b0);
    set_wb(0, 1'b1, 5'd3, 32'hDEADBEEF);
    cycle();
    chk("s2_stall_t", 64'(obs_rdy), 64'(0));
    chk("s2_gnt", 64'(obs_gnt), 64'(3'b001));
    wb_valid = '0;
    chk("s2_we", 64'(rf_we), 64'(1));
    chk("s2_reg", 64'(rf_reg_c), 64'(3));
    chk("s2_data", 64'(rf_data_c), 64'hDEADBEEF);
    cycle();
    chk("s2_stall_t1", 64'(obs_rdy), 64'(0));
    chk("s2_cleared", 64'(busy[3]), 64'(0));
    cycle();
    chk("s2_ready_t2", 64'(obs_rdy), 64'(1));
    idle();

    // Round-robin order from a fresh pointer.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_wb(i, 1'b1, 5'd0, $urandom);
    cycle(); chk("rr_0", 64'(obs_gnt), 64'(3'b001));
    cycle(); chk("rr_1", 64'(obs_gnt), 64'(3'b010));
    cycle(); chk("rr_2", 64'(obs_gnt), 64'(3'b100));
    wb_valid = 3'b101;
    cycle(); chk("rr_101a", 64'(obs_gnt), 64'(3'b001));
    cycle(); chk("rr_101b", 64'(obs_gnt), 64'(3'b100));
    chk("rr_rd0_nowe", 64'(rf_we), 64'(0));
    idle();

    // x0 destination never tracked or written.
    set_issue(5'd0, 5'd0, 5'd0, 1'b1);
    cycle(); chk("x0_issue", 64'(obs_rdy), 64'(1));
    idle();
    set_wb(1, 1'b1, 5'd0, 32'h11111111);
    cycle(); wb_valid = '0;
    chk("x0_busy", 64'(busy), 64'(0));
    chk("x0_we", 64'(rf_we), 64'(0));
    chk("x0_err", 64'(err_spur), 64'(0));

    // Spurious writeback still writes and flags the sticky error.
    set_wb(2, 1'b1, 5'd7, 32'h12345678);
    cycle(); wb_valid = '0;
    chk("spur_we", 64'(rf_we), 64'(1));
    chk("spur_reg", 64'(rf_reg_c), 64'(7));
    chk("spur_err", 64'(err_spur), 64'(1));
    cycle(); cycle();
    chk("spur_sticky", 64'(err_spur), 64'(1));

    // en=0 freezes the pending commit and gates handshakes.
    set_issue(5'd0, 5'd0, 5'd9, 1'b1);
    cycle(); idle();
    set_wb(0, 1'b1, 5'd9, 32'hA5A5A5A5);
    cycle(); wb_valid = '0;
    en = 1'b0;
    set_issue(5'd9, 5'd0, 5'd0, 1'b0);
    set_wb(1, 1'b1, 5'd0, 32'h0);
    cycle();
    chk("en0_ready", 64'(obs_rdy), 64'(0));
    chk("en0_gnt", 64'(obs_gnt), 64'(0));
    chk("en0_we", 64'(rf_we), 64'(0));
    chk("en0_busy9", 64'(busy[9]), 64'(1));
    en = 1'b1; idle();
    cycle();
    chk("en1_clear9", 64'(busy[9]), 64'(0));

    // Reset in the middle of a grant.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("rst2_err", 64'(err_spur), 64'(0));
    set_issue(5'd0, 5'd0, 5'd4, 1'b1); cycle();
    set_issue(5'd0, 5'd0, 5'd5, 1'b1); cycle();
    idle();
    chk("rst2_busy45", 64'(busy[5:4]), 64'(2'b11));
    set_wb(1, 1'b1, 5'd4, 32'hCAFEF00D);
    rst_n = 1'b0;
    cycle();
    chk("rst2_gnt", 64'(obs_gnt), 64'(3'b010));
    rst_n = 1'b1; idle();
    chk("rst2_busy", 64'(busy), 64'(0));
    chk("rst2_we", 64'(rf_we), 64'(0));
    chk("rst2_ptr", 64'(rr_ptr), 64'(0));
    for (int i = 0; i < N; i++) set_wb(i, 1'b1, 5'd0, 32'h0);
    cycle();
    chk("rst2_first_gnt", 64'(obs_gnt), 64'(3'b001));
    idle();

    // Randomized traffic with well-behaved requesters.
    rv = '0;
    for (int i = 0; i < N; i++) begin rrd[i] = '0; rdat[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      rst_n = (c != 250);
      en = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1) != 0;
      issue_rs1 = reg_addr_t'($urandom_range(0, 7));
      issue_rs2 = reg_addr_t'($urandom_range(0, 7));
      issue_rd  = reg_addr_t'($urandom_range(0, 7));
      issue_wr  = $urandom_range(0, 1) != 0;
      pend = '0;
      for (int i = 0; i < N; i++) if (rv[i]) pend[rrd[i]] = 1'b1;
      if (m_we) pend[m_reg] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          r = reg_addr_t'($urandom_range(0, 7));
          if ((r == '0 || m_busy[r] || $urandom_range(0, 19) == 0) && !pend[r]) begin
            rv[i] = 1'b1; rrd[i] = r; rdat[i] = $urandom;
            if (r != '0) pend[r] = 1'b1;
          end
        end
        set_wb(i, rv[i], rrd[i], rdat[i]);
      end
      cycle();
      if (last_g >= 0) rv[last_g] = 1'b0;
      if (!rst_n) rv = '0;
    end
    rst_n = 1'b1;
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
